// File: rtl/mvu_pkg.sv
// Shared MVU definitions: datapath widths and the job configuration record
// captured by the address generators when a job is launched.
package mvu_pkg;

   localparam int BPREC    = 6;
   localparam int BDBANKA  = 15;
   localparam int BDBANKW  = 64;
   localparam int BWLENGTH = 8;

   typedef struct packed {
      logic [BPREC-1:0]    prec;
      logic [BDBANKA-1:0]  base;
      logic [BDBANKA-1:0]  jump0;
      logic [BDBANKA-1:0]  jump1;
      logic [BDBANKA-1:0]  jump2;
      logic [BWLENGTH-1:0] length0;
      logic [BWLENGTH-1:0] length1;
      logic [BWLENGTH-1:0] length2;
   } jobCfg_t;

   // A zero precision would leave the bit counter without a terminal value.
   function automatic logic [BPREC-1:0] effPrec(input logic [BPREC-1:0] p);
      return (p == '0) ? BPREC'(1) : p;
   endfunction

endpackage

// File: rtl/outagu_nest.sv
// Bit-plane / 3-level loop counter nest producing a data-memory address.
// Steps once per handled plane; wraps back to the origin after the last plane.
module outagu_nest
   import mvu_pkg::*;
(
   input  logic               clk,
   input  logic               clr,
   input  logic               clear_i,
   input  logic               step_i,
   input  jobCfg_t            cfg_i,
   output logic [BDBANKA-1:0] addr_o,
   output logic               last_o
);

   logic [BPREC-1:0]    plane_q, plane_d;
   logic [BWLENGTH-1:0] c0_q, c0_d;
   logic [BWLENGTH-1:0] c1_q, c1_d;
   logic [BWLENGTH-1:0] c2_q, c2_d;
   logic [BDBANKA-1:0]  addr_q, addr_d;
   logic [BPREC-1:0]    planeMax;

   assign planeMax = cfg_i.prec - BPREC'(1);

   // Innermost level is the bit-plane; loop levels only advance when it wraps.
   always_comb begin
      plane_d = plane_q;
      c0_d    = c0_q;
      c1_d    = c1_q;
      c2_d    = c2_q;
      addr_d  = addr_q;
      if (clear_i) begin
         plane_d = '0;
         c0_d    = '0;
         c1_d    = '0;
         c2_d    = '0;
         addr_d  = '0;
      end else if (step_i) begin
         if (plane_q < planeMax) begin
            plane_d = plane_q + BPREC'(1);
         end else begin
            plane_d = '0;
            if (c0_q < cfg_i.length0) begin
               c0_d   = c0_q + BWLENGTH'(1);
               addr_d = addr_q + cfg_i.jump0;
            end else if (c1_q < cfg_i.length1) begin
               c0_d   = '0;
               c1_d   = c1_q + BWLENGTH'(1);
               addr_d = addr_q + cfg_i.jump1;
            end else if (c2_q < cfg_i.length2) begin
               c0_d   = '0;
               c1_d   = '0;
               c2_d   = c2_q + BWLENGTH'(1);
               addr_d = addr_q + cfg_i.jump2;
            end else begin
               c0_d   = '0;
               c1_d   = '0;
               c2_d   = '0;
               addr_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         plane_q <= '0;
         c0_q    <= '0;
         c1_q    <= '0;
         c2_q    <= '0;
         addr_q  <= '0;
      end else begin
         plane_q <= plane_d;
         c0_q    <= c0_d;
         c1_q    <= c1_d;
         c2_q    <= c2_d;
         addr_q  <= addr_d;
      end
   end

   assign last_o = (plane_q == planeMax) && (c0_q == cfg_i.length0) &&
                   (c1_q == cfg_i.length1) && (c2_q == cfg_i.length2);

   assign addr_o = cfg_i.base + addr_q + BDBANKA'(plane_q);

endmodule

// File: rtl/outagu.sv
// Output-side address generator: buffers quantized bit-planes in a 2-entry
// FIFO and writes them to the data bank in the input-side bit-serial layout.
module outagu
   import mvu_pkg::*;
(
   input  logic                clk,
   input  logic                clr,
   input  logic                start,
   input  logic [BPREC-1:0]    oprecision,
   input  logic [BDBANKA-1:0]  obaseaddr,
   input  logic [BDBANKA-1:0]  ojump0,
   input  logic [BDBANKA-1:0]  ojump1,
   input  logic [BDBANKA-1:0]  ojump2,
   input  logic [BWLENGTH-1:0] olength0,
   input  logic [BWLENGTH-1:0] olength1,
   input  logic [BWLENGTH-1:0] olength2,
   input  logic                in_valid,
   input  logic [BDBANKW-1:0]  in_data,
   output logic                in_ready,
   output logic                wr_req,
   input  logic                wr_grant,
   output logic [BDBANKA-1:0]  wr_addr,
   output logic [BDBANKW-1:0]  wr_data,
   output logic                busy,
   output logic                done
);

   jobCfg_t             cfg_q;
   jobCfg_t             jobCfg;
   jobCfg_t             wrCfg;
   logic                busy_q;
   logic                done_q;
   logic                accLast_q;
   logic [1:0]          fifoCount_q;
   logic                wrPtr_q;
   logic                rdPtr_q;
   logic [BDBANKW-1:0]  fifoMem_q [2];
   logic                startJob;
   logic                push;
   logic                pop;
   logic                accLast;
   logic                wrLast;
   logic [BDBANKA-1:0]  unusedAccAddr;

   assign jobCfg = '{prec:    effPrec(oprecision),
                     base:    obaseaddr,
                     jump0:   ojump0,
                     jump1:   ojump1,
                     jump2:   ojump2,
                     length0: olength0,
                     length1: olength1,
                     length2: olength2};

   // While idle the write address tracks the live base input, not a stale job.
   always_comb begin
      wrCfg = cfg_q;
      if (!busy_q) begin
         wrCfg.base = obaseaddr;
      end
   end

   assign startJob = start & ~busy_q;
   assign in_ready = busy_q & ~accLast_q & (fifoCount_q != 2'd2);
   assign wr_req   = (fifoCount_q != 2'd0);
   assign push     = in_valid & in_ready;
   assign pop      = wr_req & wr_grant;
   assign wr_data  = fifoMem_q[rdPtr_q];
   assign busy     = busy_q;
   assign done     = done_q;

   outagu_nest accNest (
      .clk     (clk),
      .clr     (clr),
      .clear_i (startJob),
      .step_i  (push),
      .cfg_i   (cfg_q),
      .addr_o  (unusedAccAddr),
      .last_o  (accLast)
   );

   outagu_nest wrNest (
      .clk     (clk),
      .clr     (clr),
      .clear_i (startJob),
      .step_i  (pop),
      .cfg_i   (wrCfg),
      .addr_o  (wr_addr),
      .last_o  (wrLast)
   );

   // Job control and FIFO; push and pop are independent, so a full FIFO
   // only reopens the cycle after a grant drains an entry.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cfg_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         accLast_q    <= 1'b0;
         fifoCount_q  <= 2'd0;
         wrPtr_q      <= 1'b0;
         rdPtr_q      <= 1'b0;
         fifoMem_q[0] <= '0;
         fifoMem_q[1] <= '0;
      end else begin
         done_q <= 1'b0;
         if (startJob) begin
            cfg_q       <= jobCfg;
            busy_q      <= 1'b1;
            accLast_q   <= 1'b0;
            fifoCount_q <= 2'd0;
            wrPtr_q     <= 1'b0;
            rdPtr_q     <= 1'b0;
         end else begin
            if (push) begin
               fifoMem_q[wrPtr_q] <= in_data;
               wrPtr_q            <= ~wrPtr_q;
               if (accLast) begin
                  accLast_q <= 1'b1;
               end
            end
            if (pop) begin
               rdPtr_q <= ~rdPtr_q;
               if (wrLast) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            case ({push, pop})
               2'b10:   fifoCount_q <= fifoCount_q + 2'd1;
               2'b01:   fifoCount_q <= fifoCount_q - 2'd1;
               default: fifoCount_q <= fifoCount_q;
            endcase
         end
      end
   end

endmodule

// File: doc/outagu.md
# outagu

Output-side address generator and write-back buffer for the MVU datapath. It accepts quantized output bit-planes from the shift-accumulate/quantizer stage and writes them into the data memory bank MSB-plane first. Addresses follow a base + 3-level jump/length nest + per-bit zig-zag offset, so results land in the same bit-serial layout that the input-side address generator reads back for the next layer. A 2-entry FIFO decouples the producer from data-memory write arbitration.

## Interface
- BPREC, 6: bitwidth of precision fields
- BDBANKA, 15: data memory address width
- BDBANKW, 64: data memory word width (one bit-plane, one bit per lane)
- BWLENGTH, 8: loop length field width
- clk  in  1  clock; all state on rising edge
- clr  in  1  reset, asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; launches a job when idle
- oprecision  in  BPREC  output precision in bit-planes; 0 treated as 1
- obaseaddr  in  BDBANKA  job base address
- ojump0..ojump2  in  BDBANKA each  loop jumps, two's complement, level 0 innermost
- olength0..olength2  in  BWLENGTH each  loop iteration count minus 1
- in_valid  in  1  producer has a bit-plane
- in_data  in  BDBANKW  bit-plane, MSB plane of each element first
- in_ready  out  1  block accepts in_data this cycle
- wr_req  out  1  write request to data memory
- wr_grant  in  1  arbiter grant; write happens when wr_req & wr_grant
- wr_addr  out  BDBANKA  write address
- wr_data  out  BDBANKW  write data
- busy  out  1  job active
- done  out  1  one-cycle pulse after the last write

## Operation
- Config inputs are sampled only at start and must be held stable while busy.
- start while idle: clear both counter nests and FIFO state, then busy=1. start while busy is ignored.
- Counter nest state: bit (0..oprec-1), c0, c1, c2, and addr accumulator (BDBANKA).
- Nest step, applied per event:
  - if bit<oprec-1: bit++.
  - else bit=0 and:
    - if c0<olength0: c0++, addr+=ojump0;
    - elif c1<olength1: c0=0, c1++, addr+=ojump1;
    - elif c2<olength2: c0=c1=0, c2++, addr+=ojump2;
    - else last.
- Total planes per job: oprec*(ol0+1)*(ol1+1)*(ol2+1).
- The accept nest steps on every in_valid & in_ready. The plane that reaches last sets acc_last.
- The write nest steps on every wr_req & wr_grant.
- wr_addr = obaseaddr + addr + bit. All arithmetic is modulo 2^BDBANKA; negative jumps wrap.
- in_ready = busy & !acc_last & fifo_count<2. Accept is not gated by same-cycle pop.
- wr_req = fifo_count!=0. wr_data = FIFO head. Order is strictly preserved.
- Write of the last plane: busy drops and done pulses on the following cycle; FIFO is empty.
- in_valid while idle or after acc_last is not accepted; in_ready stays 0.

## Timing
- Reset values: in_ready=0, wr_req=0, wr_addr=obaseaddr+0 (addr, bit =0), wr_data=0, busy=0, done=0, FIFO count 0.
- start at edge N: busy=1 and in_ready=1 from cycle N+1.
- Accept at edge N: wr_req=1 in cycle N+1 (1-cycle latency, no bypass).
- Simultaneous push and pop with count=1: count stays 1, data advances.
- Full FIFO: in_ready=0 until a grant pops an entry, then in_ready=1 in the next cycle.
- wr_addr/wr_data are stable while wr_req=1 and wr_grant=0.
- clr mid-job: all outputs return to reset values immediately. No partial done is produced.

## Structure
- Shared package mvu_pkg: BPREC/BDBANKA/BDBANKW/BWLENGTH defaults and the job-config record type (precision, base, jumps, lengths).
- Sub-module outagu_nest: bit/c0/c1/c2/addr counters with step, clear, and last outputs. It is instantiated twice, once for the accept side and once for the write side.
- The FIFO is inline: 2 registers plus a count.

## Test plan
- Basic job: oprec=2, ol0=1, ol1=ol2=0, ojump0=5, base=100, grant tied 1, 4 back-to-back planes -> wr_addr 100,101,105,106 in order. done pulses 1 cycle after the 4th write, and busy falls with it.
- Nest/wrap: oprec=1, ol0=1, ol1=1, j0=2, j1=-3, base=0 -> addresses 0, 2, 32767, 1.
- Backpressure: wr_grant=0 for 6 cycles with in_valid=1 -> exactly 2 accepts, then in_ready=0. After grant, data D0,D1,D2 are written in order with no loss or duplication.
- Overrun guard: after the last plane is accepted, hold in_valid=1 -> in_ready stays 0 and the write count equals the total plane count.
- Reset mid-job: assert clr after 2 of 8 writes -> busy=0, wr_req=0, done never pulses. A new start rewrites from base at bit 0.
- Ignored controls: start while busy changes nothing. in_valid while idle -> no accept and wr_req stays 0.
